seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
// Iterative 32x32 -> 64-bit integer multiplier for the MIPS execute stage (MULT/MULTU).
// Operands and signedness are captured on a start pulse. The product is computed
// one shift-add step per cycle on operand magnitudes, then sign-corrected.
// s updates once per operation; done pulses for one cycle when s becomes valid.
// PARAMETERS
// WIDTH  32  operand width; product width is 2*WIDTH (only 32 is verified)
// PORTS
// clk        in   1   clock, all state updates on rising edge
// rst        in   1   synchronous active-high reset
// start      in   1   pulse: capture a, b, is_signed and begin a multiply
// is_signed  in   1   1 = two's-complement operands (MULT), 0 = unsigned (MULTU)
// a          in   32  multiplicand, sampled only on a start cycle
// b          in   32  multiplier, sampled only on a start cycle
// s          out  64  product register; holds the last completed result
// busy       out  1   high while an operation is in progress
// done       out  1   one-cycle pulse in the cycle s first shows a new result
// BEHAVIOUR
// - Reset (rst=1 at an edge): s=0, busy=0, done=0, FSM->IDLE, counter=0.
//   rst overrides start. Reset mid-operation aborts the operation with no result.
// - FSM states: IDLE -> RUN (32 cycles) -> FIX (1 cycle) -> IDLE.
// - Start edge E (start=1, rst=0), accepted in any state:
//   - Capture mag_a = |a| and mag_b = |b| if is_signed, else raw a and b.
//   - Capture neg = is_signed & (a[31]^b[31]); clear acc (64 b) and counter.
//   - busy=1 from E. start while busy aborts the current op and restarts.
// - RUN, one step per edge:
//   - If mag_b[0], acc += mag_a shifted left by the counter; shift mag_b right 1.
//   - Any equivalent shift-add form is allowed; it must be exactly 32 steps.
// - FIX edge: s <= neg ? -acc : acc (64-bit two's complement); done=1; busy=0.
// - Fixed latency: result valid after edge E+33 (done high that cycle only),
//   i.e. well within 64 cycles of start. s is unchanged during RUN and FIX.
// - Magnitudes are 32-bit unsigned, so |-2^31| = 2^31 is exact.
//   Signed -2^31*-2^31 = 2^62 with no overflow. Unsigned products never overflow 64 b.
// - A zero operand still takes full latency, giving s=0 (never -0 issues).
// - a, b, is_signed changes while busy have no effect.
// - After done, s holds until the next FIX edge or reset.
// TESTING
// - signed 87359729*23422 -> s=2046139572638 after 33 edges, done pulses once
// - signed -77*999 -> s=64'hFFFFFFFFFFFED385 (-76923)
// - signed 809843053*-328932 -> s=-266383295109396 (64-bit two's complement)
// - signed -2147483648*-2147483648 -> s=64'h4000000000000000
//   (same operands unsigned -> same value)
// - unsigned 33329255*45825983 -> s=1527345873032665
// - unsigned 32'hFFFFFFFF^2 -> s=64'hFFFFFFFE00000001; the same operands signed -> s=1
// - control checks:
//   - rst asserted mid-RUN -> s=0, busy=0, no done.
//   - Restart mid-RUN with new start -> only the new result appears,
//     33 edges after the restart.

Source files
------------

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier (MULT/MULTU): one partial-product step per cycle
// on operand magnitudes, followed by a single sign-correction cycle.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] s,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  logic [1:0]         state_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   mag_a_r;
  logic [WIDTH-1:0]   mag_b_r;
  logic [2*WIDTH-1:0] acc_r;
  logic               neg_r;
  logic [2*WIDTH-1:0] addend_s;

  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1) exactly.
  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] x, input logic sgn);
    if (sgn && x[WIDTH-1]) begin
      mag_of = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      mag_of = x;
    end
  endfunction

  // Multiplicand aligned to the current step's bit position.
  always_comb begin
    addend_s = {{WIDTH{1'b0}}, mag_a_r} << cnt_r;
  end

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      mag_a_r <= {WIDTH{1'b0}};
      mag_b_r <= {WIDTH{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      neg_r   <= 1'b0;
      s       <= {(2*WIDTH){1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      // A start in any state discards whatever was in flight.
      state_r <= ST_RUN;
      cnt_r   <= {CW{1'b0}};
      mag_a_r <= mag_of(a, is_signed);
      mag_b_r <= mag_of(b, is_signed);
      acc_r   <= {(2*WIDTH){1'b0}};
      neg_r   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mag_b_r[0]) begin
            acc_r <= acc_r + addend_s;
          end
          mag_b_r <= mag_b_r >> 1;
          cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          done    <= 1'b0;
          if (cnt_r == CW'(WIDTH-1)) begin
            state_r <= ST_FIX;
          end
        end
        ST_FIX: begin
          s       <= neg_r ? (~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_r;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        ST_IDLE: begin
          done <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: directed vectors push expected results,
// a negedge monitor pops and compares value and latency on every done pulse.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] s;
  logic        busy;
  logic        done;

  typedef struct {
    logic [63:0] val;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_s = 64'd0;

  seq_multiplier #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .s(s), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (s !== e.val || cyc != e.due || busy !== 1'b0) begin
          errors++;
          $display("FAIL result: got s=%h cyc=%0d busy=%b expected s=%h cyc=%0d busy=0",
                   s, cyc, busy, e.val, e.due);
        end
        model_s = e.val;
      end
    end
  end

  task automatic issue(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp, input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1; is_signed = sgn; a = x; b = y;
    if (push) begin
      e.val = exp;
      e.due = cyc + 34;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; is_signed = ~sgn;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("s_held_in_run", s, model_s);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || q.size() != 0) && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (n >= 80) begin
      checks++; errors++;
      $display("FAIL timeout: got busy=%b pending=%0d expected idle", busy, q.size());
    end
    repeat (3) @(negedge clk);
    check("s_hold_after_done", s, model_s);
  endtask

  task automatic run(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                     input logic [63:0] exp);
    issue(sgn, x, y, exp, 1'b1);
    wait_idle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_s", s, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);

    run(1'b1, 32'd87359729, 32'd23422, 64'd2046139572638);
    run(1'b1, 32'hFFFFFFB3, 32'd999, 64'hFFFFFFFFFFFED385);
    run(1'b1, 32'd809843053, 32'hFFFAFB1C, -64'sd266383295109396);
    run(1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000);
    run(1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000);
    run(1'b0, 32'd33329255, 32'd45825983, 64'd1527345873032665);
    run(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    run(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1);
    run(1'b1, 32'd7, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFF9);
    run(1'b1, 32'd0, 32'hFFFFFFFB, 64'd0);
    run(1'b0, 32'h80000000, 32'd3, 64'h0000000180000000);

    // Restart mid-run: only the second operation may produce a result.
    issue(1'b1, 32'd100, 32'd200, 64'd0, 1'b0);
    repeat (10) @(negedge clk);
    issue(1'b0, 32'd12345, 32'd1000, 64'd12345000, 1'b1);
    wait_idle();

    // Reset mid-run aborts without a done pulse and clears s.
    issue(1'b0, 32'd5, 32'd6, 64'd0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_s", s, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_done", {63'd0, done}, 64'd0);
    model_s = 64'd0;
    repeat (45) @(negedge clk);
    check("rst_mid_s_later", s, 64'd0);

    check("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
